rp_acq_wctrl: RTL and testbench
===============================

# rp_acq_wctrl

Acquisition write controller for one ADC channel. It sits directly upstream of the acquisition BRAM. It takes decimated ADC samples, runs the arm/trigger/post-trigger state machine, and drives the BRAM write pointer, data, valid and write-enable. It also captures the write pointer at the trigger so software can locate pre-trigger data in the circular buffer.

## Interface
Parameters:
- DW, 14, sample width
- RSZ, 14, BRAM address width; buffer depth 2^RSZ

Ports:
- adc_clk_i  in  1  ADC clock
- adc_rstn_i  in  1  reset, asynchronous, active-low
- adc_dat_i  in  DW  decimated sample
- adc_val_i  in  1  sample valid, from the decimator
- arm_i  in  1  single-cycle pulse: start acquisition
- abort_i  in  1  single-cycle pulse: stop and return to IDLE
- trig_i  in  1  single-cycle trigger pulse, already selected and edge-detected
- dly_i  in  32  number of valid samples to write after the trigger sample
- pre_i  in  RSZ  required pre-trigger sample count; used only with the macro described under Configuration
- bram_wp_o  out  RSZ  write address for bram_dat_o
- bram_dat_o  out  DW  sample to BRAM
- bram_val_o  out  1  registered adc_val_i
- bram_we_o  out  1  write enable; high in ARMED and TRIGD
- trig_wp_o  out  RSZ  write address captured at the accepted trigger
- armed_o  out  1  state is ARMED
- trigd_o  out  1  state is TRIGD
- done_o  out  1  state is DONE

## Operation
- The state machine has four states: IDLE, ARMED, TRIGD and DONE. Reset enters IDLE.
- Transition priority each cycle, highest first:
  - abort_i: any state goes to IDLE.
  - arm_i in IDLE or DONE: go to ARMED and clear the pre-trigger counter. arm_i is ignored in ARMED and TRIGD.
  - Accepted trig_i in ARMED:
    - If dly_i == 0, go to DONE.
    - Otherwise go to TRIGD and load post_cnt with dly_i.
    - In both cases load trig_wp_o with the current wp.
    - trig_i is ignored outside ARMED.
  - In TRIGD, each adc_val_i decrements post_cnt. A valid sample arriving while post_cnt == 1 moves the state to DONE.
- Write pointer wp (internal, RSZ bits):
  - Increments by 1 on adc_val_i while in ARMED or TRIGD, including the cycle in which the state is left.
  - Wraps from 2^RSZ-1 to 0.
  - Is not cleared by arm_i or abort_i; it is cleared only by reset.
- The trigger-cycle sample is written if valid, at address trig_wp_o. It does not count toward dly_i. Exactly dly_i valid samples are written after it, at addresses trig_wp_o+1 … trig_wp_o+dly_i (mod 2^RSZ).
- dly_i is sampled only at trigger acceptance. Changing it later has no effect on the current acquisition.
- post_cnt is 32 bits and unsigned.

## Timing
- All outputs are registered. Reset value of every output is 0.
- Cycle N inputs appear on the outputs at cycle N+1:
  - bram_dat_o = adc_dat_i
  - bram_val_o = adc_val_i
  - bram_wp_o = wp at N
  - bram_we_o = 1 if the state at N is ARMED or TRIGD
- The sample on the cycle that leaves TRIGD for DONE is written. From the next sample onward bram_we_o = 0.
- armed_o, trigd_o and done_o reflect the registered state. They change one cycle after the causing input.
- trig_wp_o updates one cycle after trigger acceptance and holds until the next accepted trigger or reset.
- Asserting reset mid-acquisition immediately forces IDLE and zeroes all outputs and wp. When reset is released, the block waits for arm_i.
- abort_i on the same cycle as a valid sample in ARMED or TRIGD:
  - The sample is still written, because that cycle's state is a writing state.
  - wp still increments.

## Configuration
- Macro: RP_ACQ_PREFILL_EN.
- Defined:
  - A pre-trigger counter counts valid samples written in ARMED and saturates at pre_i.
  - trig_i is accepted only when the counter >= pre_i. Earlier triggers are dropped, not queued.
  - With pre_i = 0, triggers are accepted immediately.
- Undefined:
  - No pre-trigger counter is built and pre_i is unused.
  - trig_i is accepted on any cycle in ARMED.

## Test plan
- Reset then idle (RSZ=4): adc_val_i = 1 continuously, no arm -> bram_we_o = 0, wp stays 0, all status outputs 0.
- Basic capture, dly_i = 5: arm, then 3 valid samples, then trig_i with valid -> trig_wp_o = 3. Samples at addresses 3..8 are written with bram_we_o = 1, then done_o = 1 and bram_we_o = 0.
- Wrap-around (RSZ=4), dly_i = 20: arm, trigger at wp = 10 -> bram_wp_o passes 15 -> 0 and ends at address 14 (10+20 mod 16). done_o = 1.
- dly_i = 0 with a gapped adc_val_i (every 3rd cycle): trigger -> DONE in one cycle. Only the trigger sample is written, if valid.
- abort_i in TRIGD at post_cnt = 4 -> IDLE next cycle, bram_we_o = 0, done_o = 0. A subsequent arm_i works normally.
- RP_ACQ_PREFILL_EN defined, pre_i = 8: trig_i after 5 valid samples is ignored (trigd_o stays 0). trig_i after the 8th valid sample is accepted and trig_wp_o = start wp + 8.

Source files
------------

// File: rtl/rp_acq_wctrl.sv
// Acquisition write controller: arm/trigger/post-trigger FSM driving BRAM writes.
// Optional macro RP_ACQ_PREFILL_EN gates trigger acceptance on a pre-trigger sample count.
module rp_acq_wctrl #(
  parameter int unsigned DW  = 14,
  parameter int unsigned RSZ = 14
) (
  input  logic           adc_clk_i,
  input  logic           adc_rstn_i,
  input  logic [DW-1:0]  adc_dat_i,
  input  logic           adc_val_i,
  input  logic           arm_i,
  input  logic           abort_i,
  input  logic           trig_i,
  input  logic [31:0]    dly_i,
  input  logic [RSZ-1:0] pre_i,
  output logic [RSZ-1:0] bram_wp_o,
  output logic [DW-1:0]  bram_dat_o,
  output logic           bram_val_o,
  output logic           bram_we_o,
  output logic [RSZ-1:0] trig_wp_o,
  output logic           armed_o,
  output logic           trigd_o,
  output logic           done_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_TRIGD = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]     state, state_n;
  logic [RSZ-1:0] wp;
  logic [31:0]    post_cnt;
  logic           wr_st, arm_go, pre_ok, trig_acc, trig_take;

  assign wr_st     = (state == ST_ARMED) || (state == ST_TRIGD);
  assign arm_go    = arm_i && !abort_i && ((state == ST_IDLE) || (state == ST_DONE));
  assign trig_acc  = trig_i && (state == ST_ARMED) && pre_ok;
  assign trig_take = trig_acc && !abort_i;

`ifdef RP_ACQ_PREFILL_EN
  logic [RSZ-1:0] pre_cnt;

  // Saturates at pre_i so a later trigger is accepted without further counting.
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i)
      pre_cnt <= '0;
    else if (arm_go)
      pre_cnt <= '0;
    else if ((state == ST_ARMED) && adc_val_i && (pre_cnt < pre_i))
      pre_cnt <= pre_cnt + 1'b1;
  end

  assign pre_ok = (pre_cnt >= pre_i);
`else
  logic unused_pre;
  assign unused_pre = ^pre_i;
  assign pre_ok     = 1'b1;
`endif

  always_comb begin
    state_n = state;
    if (abort_i) begin
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: if (arm_i) state_n = ST_ARMED;
        ST_ARMED:         if (trig_acc) state_n = (dly_i == 32'd0) ? ST_DONE : ST_TRIGD;
        ST_TRIGD:         if (adc_val_i && (post_cnt == 32'd1)) state_n = ST_DONE;
        default:          state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      state      <= ST_IDLE;
      wp         <= '0;
      post_cnt   <= '0;
      trig_wp_o  <= '0;
      bram_wp_o  <= '0;
      bram_dat_o <= '0;
      bram_val_o <= 1'b0;
      bram_we_o  <= 1'b0;
      armed_o    <= 1'b0;
      trigd_o    <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      state <= state_n;
      if (wr_st && adc_val_i)
        wp <= wp + 1'b1;
      if (trig_take) begin
        trig_wp_o <= wp;
        post_cnt  <= dly_i;
      end else if ((state == ST_TRIGD) && adc_val_i) begin
        post_cnt  <= post_cnt - 32'd1;
      end
      bram_wp_o  <= wp;
      bram_dat_o <= adc_dat_i;
      bram_val_o <= adc_val_i;
      bram_we_o  <= wr_st;
      armed_o    <= (state_n == ST_ARMED);
      trigd_o    <= (state_n == ST_TRIGD);
      done_o     <= (state_n == ST_DONE);
    end
  end

endmodule

// File: tb/tb_rp_acq_wctrl.sv
// Directed bench for rp_acq_wctrl with a 16-entry buffer (RSZ=4).
module tb_rp_acq_wctrl;

  localparam int unsigned DW  = 14;
  localparam int unsigned RSZ = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [DW-1:0]  adc_dat_i;
  logic           adc_val_i, arm_i, abort_i, trig_i;
  logic [31:0]    dly_i;
  logic [RSZ-1:0] pre_i;
  logic [RSZ-1:0] bram_wp_o, trig_wp_o;
  logic [DW-1:0]  bram_dat_o;
  logic           bram_val_o, bram_we_o, armed_o, trigd_o, done_o;

  int n_cmp = 0;
  int n_err = 0;

  rp_acq_wctrl #(.DW(DW), .RSZ(RSZ)) dut (
    .adc_clk_i (clk),
    .adc_rstn_i(rst_n),
    .adc_dat_i (adc_dat_i),
    .adc_val_i (adc_val_i),
    .arm_i     (arm_i),
    .abort_i   (abort_i),
    .trig_i    (trig_i),
    .dly_i     (dly_i),
    .pre_i     (pre_i),
    .bram_wp_o (bram_wp_o),
    .bram_dat_o(bram_dat_o),
    .bram_val_o(bram_val_o),
    .bram_we_o (bram_we_o),
    .trig_wp_o (trig_wp_o),
    .armed_o   (armed_o),
    .trigd_o   (trigd_o),
    .done_o    (done_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock with the given inputs; outputs are sampled 1 ns after the edge.
  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic a,
                     input logic t, input logic ab);
    adc_val_i = v; adc_dat_i = d; arm_i = a; trig_i = t; abort_i = ab;
    @(posedge clk);
    #1;
    arm_i = 1'b0; trig_i = 1'b0; abort_i = 1'b0;
  endtask

  function automatic logic [2:0] st();
    return {armed_o, trigd_o, done_o};
  endfunction

  initial begin
    rst_n = 1'b0;
    adc_dat_i = '0; adc_val_i = 1'b0; arm_i = 1'b0; abort_i = 1'b0; trig_i = 1'b0;
    dly_i = 32'd0; pre_i = '0;
    #23;
    check("rst_we", {31'd0, bram_we_o}, 32'd0);
    check("rst_st", {29'd0, st()}, 32'd0);
    check("rst_wp", {28'd0, bram_wp_o}, 32'd0);
    check("rst_twp", {28'd0, trig_wp_o}, 32'd0);
    check("rst_val", {31'd0, bram_val_o}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Idle with continuous valid: nothing written, wp frozen.
    for (int i = 0; i < 4; i++) cyc(1'b1, 14'h0A0, 1'b0, 1'b0, 1'b0);
    check("idle_we", {31'd0, bram_we_o}, 32'd0);
    check("idle_wp", {28'd0, bram_wp_o}, 32'd0);
    check("idle_st", {29'd0, st()}, 32'd0);
    check("idle_val", {31'd0, bram_val_o}, 32'd1);
    check("idle_dat", {18'd0, bram_dat_o}, 32'h0A0);

    // Basic capture, dly=5, wp=0.
    cyc(1'b0, 14'h0, 1'b1, 1'b0, 1'b0);
    check("arm_st", {29'd0, st()}, 32'b100);
    check("arm_we", {31'd0, bram_we_o}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 14'h100 + 14'(i), 1'b0, 1'b0, 1'b0);
      check("pre_addr", {28'd0, bram_wp_o}, i);
    end
    check("pre_we", {31'd0, bram_we_o}, 32'd1);
    dly_i = 32'd5;
    cyc(1'b1, 14'h1AB, 1'b0, 1'b1, 1'b0);
    check("trg_st", {29'd0, st()}, 32'b010);
    check("trg_twp", {28'd0, trig_wp_o}, 32'd3);
    check("trg_addr", {28'd0, bram_wp_o}, 32'd3);
    check("trg_dat", {18'd0, bram_dat_o}, 32'h1AB);
    dly_i = 32'd1;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 14'h200 + 14'(i), 1'b0, 1'b0, 1'b0);
      check("post_addr", {28'd0, bram_wp_o}, 32'd4 + i);
      check("post_we", {31'd0, bram_we_o}, 32'd1);
    end
    check("bas_done", {29'd0, st()}, 32'b001);
    cyc(1'b1, 14'h0, 1'b0, 1'b0, 1'b0);
    check("bas_we_off", {31'd0, bram_we_o}, 32'd0);
    check("bas_wp_hold", {28'd0, bram_wp_o}, 32'd9);

    // Wrap-around, dly=20, trigger at wp=10.
    cyc(1'b0, 14'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 14'h0, 1'b0, 1'b0, 1'b0);
    dly_i = 32'd20;
    cyc(1'b1, 14'h0, 1'b0, 1'b1, 1'b0);
    check("wrap_twp", {28'd0, trig_wp_o}, 32'd10);
    for (int i = 1; i <= 20; i++) begin
      cyc(1'b1, 14'h0, 1'b0, 1'b0, 1'b0);
      if (i == 5)  check("wrap_15", {28'd0, bram_wp_o}, 32'd15);
      if (i == 6)  check("wrap_0", {28'd0, bram_wp_o}, 32'd0);
      if (i == 19) check("wrap_notdone", {29'd0, st()}, 32'b010);
    end
    check("wrap_end", {28'd0, bram_wp_o}, 32'd14);
    check("wrap_done", {29'd0, st()}, 32'b001);

    // dly=0 with gapped valid; wp=15.
    cyc(1'b0, 14'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 14'h0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 14'h0, 1'b0, 1'b0, 1'b0);
    dly_i = 32'd0;
    cyc(1'b1, 14'h3C3, 1'b0, 1'b1, 1'b0);
    check("d0_done", {29'd0, st()}, 32'b001);
    check("d0_twp", {28'd0, trig_wp_o}, 32'd15);
    check("d0_we", {31'd0, bram_we_o}, 32'd1);
    check("d0_dat", {18'd0, bram_dat_o}, 32'h3C3);
    cyc(1'b0, 14'h0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 14'h0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 14'h0, 1'b0, 1'b0, 1'b0);
    check("d0_we_off", {31'd0, bram_we_o}, 32'd0);
    check("d0_wp", {28'd0, bram_wp_o}, 32'd0);

    // Abort in TRIGD at post_cnt=4; wp=0.
    cyc(1'b0, 14'h0, 1'b1, 1'b0, 1'b0);
    dly_i = 32'd6;
    cyc(1'b1, 14'h0, 1'b0, 1'b1, 1'b0);
    check("ab_twp", {28'd0, trig_wp_o}, 32'd0);
    cyc(1'b1, 14'h0, 1'b1, 1'b0, 1'b0);
    check("ab_arm_ign", {29'd0, st()}, 32'b010);
    cyc(1'b1, 14'h0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 14'h155, 1'b0, 1'b0, 1'b1);
    check("ab_st", {29'd0, st()}, 32'b000);
    check("ab_we_last", {31'd0, bram_we_o}, 32'd1);
    check("ab_addr", {28'd0, bram_wp_o}, 32'd3);
    cyc(1'b1, 14'h0, 1'b0, 1'b0, 1'b0);
    check("ab_we_off", {31'd0, bram_we_o}, 32'd0);
    check("ab_wp", {28'd0, bram_wp_o}, 32'd4);
    cyc(1'b1, 14'h0, 1'b0, 1'b1, 1'b0);
    check("idle_trg_ign", {29'd0, st()}, 32'b000);
    check("idle_twp", {28'd0, trig_wp_o}, 32'd0);
    cyc(1'b0, 14'h0, 1'b1, 1'b0, 1'b0);
    check("rearm", {29'd0, st()}, 32'b100);
    dly_i = 32'd1;
    cyc(1'b1, 14'h0, 1'b0, 1'b1, 1'b0);
    check("rearm_twp", {28'd0, trig_wp_o}, 32'd4);
    cyc(1'b1, 14'h0, 1'b0, 1'b0, 1'b0);
    check("rearm_done", {29'd0, st()}, 32'b001);
    check("rearm_addr", {28'd0, bram_wp_o}, 32'd5);

    // Pre-trigger gating with pre_i=8; wp=6.
    pre_i = 4'd8;
    dly_i = 32'd2;
    cyc(1'b0, 14'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 14'h0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 14'h0, 1'b0, 1'b1, 1'b0);
`ifdef RP_ACQ_PREFILL_EN
    check("pf_early", {29'd0, st()}, 32'b100);
    for (int i = 0; i < 3; i++) cyc(1'b1, 14'h0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 14'h0, 1'b0, 1'b1, 1'b0);
    check("pf_acc", {29'd0, st()}, 32'b010);
    check("pf_twp", {28'd0, trig_wp_o}, 32'd14);
`else
    check("nopf_acc", {29'd0, st()}, 32'b010);
    check("nopf_twp", {28'd0, trig_wp_o}, 32'd11);
`endif
    cyc(1'b0, 14'h0, 1'b0, 1'b0, 1'b1);
    check("pf_abort", {29'd0, st()}, 32'b000);

    // Asynchronous reset mid-acquisition.
    pre_i = '0;
    cyc(1'b0, 14'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 14'h0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 14'h0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("ar_st", {29'd0, st()}, 32'b000);
    check("ar_we", {31'd0, bram_we_o}, 32'd0);
    check("ar_wp", {28'd0, bram_wp_o}, 32'd0);
    check("ar_twp", {28'd0, trig_wp_o}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    cyc(1'b1, 14'h0, 1'b0, 1'b1, 1'b0);
    check("ar_trg_ign", {29'd0, st()}, 32'b000);
    cyc(1'b0, 14'h0, 1'b1, 1'b0, 1'b0);
    dly_i = 32'd0;
    cyc(1'b1, 14'h0, 1'b0, 1'b1, 1'b0);
    check("ar_done", {29'd0, st()}, 32'b001);
    check("ar_twp0", {28'd0, trig_wp_o}, 32'd0);
    check("ar_addr0", {28'd0, bram_wp_o}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
